clock_div_scheduler: RTL and testbench

CLOCK_DIV_SCHEDULER -- requirements
Module: clock_div_scheduler

---
 rtl/clock_div_scheduler.sv | 133 +++++++++++++
 tb/tb_clock_div_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_scheduler
// Brief    : Programmable clock divider whose divisor is changed by two
//            round-robin arbitrated requesters, applied on period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module clock_div_scheduler #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         req_valid,
    input  logic [2*CNT_W-1:0] req_div,
    output logic [1:0]         req_ready,
    output logic               grant_id,
    output logic               clk_out,
    output logic               clk_pulse,
    output logic [CNT_W-1:0]   cur_div,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pending;
    logic             r_rr_ptr;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_div_nx;
    logic [CNT_W-1:0] w_pending_nx;
    logic [CNT_W-1:0] w_req_sel;
    logic [1:0]       w_elig;
    logic             w_accept;
    logic             w_gnt;
    logic             w_bad;
    logic             w_period_end;
    logic             w_clk_out_nx;
    logic             w_pulse_nx;

    // A requester still holding valid while its ready pulse is out is not re-accepted.
    assign w_elig       = req_valid & ~req_ready;
    assign w_accept     = (r_state != ST_PEND) && (w_elig != 2'b00);
    assign w_gnt        = (w_elig == 2'b11) ? r_rr_ptr : w_elig[1];
    assign w_req_sel    = w_gnt ? req_div[CNT_W +: CNT_W] : req_div[0 +: CNT_W];
    assign w_bad        = (w_req_sel < CNT_W'(2));
    assign w_period_end = (r_cnt == (cur_div - CNT_W'(1)));

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_div_nx     = cur_div;
        w_pending_nx = r_pending;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx = '0;
                if (w_accept) begin
                    if (!w_bad) begin
                        w_div_nx = w_req_sel;
                    end
                end else if (enable) begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cnt_nx = w_period_end ? '0 : (r_cnt + CNT_W'(1));
                if (w_accept && !w_bad) begin
                    w_pending_nx = w_req_sel;
                    w_state_nx   = ST_PEND;
                end else if (w_period_end && !enable) begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_PEND: begin
                w_cnt_nx = w_period_end ? '0 : (r_cnt + CNT_W'(1));
                if (w_period_end) begin
                    w_div_nx   = r_pending;
                    w_state_nx = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with r_cnt.
    assign w_clk_out_nx = (w_state_nx != ST_IDLE) && (w_cnt_nx < (w_div_nx >> 1));
    assign w_pulse_nx   = (w_state_nx != ST_IDLE) && (w_cnt_nx == '0);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_rr_ptr  <= 1'b0;
            cur_div   <= c_default_div;
            clk_out   <= 1'b0;
            clk_pulse <= 1'b0;
            req_ready <= 2'b00;
            grant_id  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_pending <= w_pending_nx;
            cur_div   <= w_div_nx;
            clk_out   <= w_clk_out_nx;
            clk_pulse <= w_pulse_nx;
            busy      <= (w_state_nx == ST_PEND);
            req_ready <= w_accept ? (2'b01 << w_gnt) : 2'b00;
            err       <= w_accept && w_bad;
            if (w_accept) begin
                grant_id <= w_gnt;
                r_rr_ptr <= ~w_gnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_div_scheduler
// Brief    : Vector table, directed corner sequences and randomized traffic
//            checked against a period-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_div_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_div = 16'h0;
    logic [1:0]  req_ready;
    logic        grant_id;
    logic        clk_out;
    logic        clk_pulse;
    logic [7:0]  cur_div;
    logic        busy;
    logic        err;

    clock_div_scheduler #(.CNT_W(8), .DEFAULT_DIV(2)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .enable   (enable),
        .req_valid(req_valid),
        .req_div  (req_div),
        .req_ready(req_ready),
        .grant_id (grant_id),
        .clk_out  (clk_out),
        .clk_pulse(clk_pulse),
        .cur_div  (cur_div),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk_in = ~clk_in;

    // {req_ready, grant_id, clk_out, clk_pulse, cur_div, busy, err}
    logic [14:0] w_dut;
    assign w_dut = {req_ready, grant_id, clk_out, clk_pulse, cur_div, busy, err};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: running flag, position within the period, divisors.
    logic       m_run, m_pend, m_fav, m_gid, m_err;
    logic [1:0] m_ready;
    int         m_phase, m_div, m_pending;

    function automatic logic [14:0] model_vec();
        logic hi, first;
        hi    = m_run && (m_phase < m_div / 2);
        first = m_run && (m_phase == 0);
        return {m_ready, m_gid, hi, first, 8'(m_div), m_pend, m_err};
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_fav = 0; m_gid = 0; m_err = 0;
        m_ready = 2'b00; m_phase = 0; m_div = 2; m_pending = 0;
    endtask

    task automatic model_step(input logic en, input logic [1:0] v, input logic [15:0] d);
        logic [1:0] elig, n_ready;
        logic       can, g, last;
        int         rq;
        elig    = v & ~m_ready;
        can     = !m_pend && (elig != 2'b00);
        g       = (elig == 2'b11) ? m_fav : elig[1];
        rq      = g ? int'(d[15:8]) : int'(d[7:0]);
        last    = m_run && (m_phase == m_div - 1);
        n_ready = 2'b00;
        m_err   = 0;
        if (can) begin
            n_ready[g] = 1'b1;
            m_gid = g;
            m_fav = !g;
            m_err = (rq < 2);
        end
        if (!m_run) begin
            if (can) begin
                if (rq >= 2) m_div = rq;
            end else if (en) begin
                m_run = 1; m_phase = 0;
            end
        end else begin
            m_phase = last ? 0 : m_phase + 1;
            if (m_pend) begin
                if (last) begin
                    m_div = m_pending; m_pend = 0; m_run = en;
                end
            end else if (can && rq >= 2) begin
                m_pending = rq; m_pend = 1;
            end else if (last && !en) begin
                m_run = 0;
            end
        end
        m_ready = n_ready;
    endtask

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (ready,gid,clk,pulse,div,busy,err)", name, act, exp);
        end
    endtask

    task automatic tick(input logic en, input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
        enable    = en;
        req_valid = v;
        req_div   = {d1, d0};
        model_step(en, v, {d1, d0});
        @(posedge clk_in);
        #1;
        check("model", w_dut, model_vec());
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check("async_reset", w_dut, {2'b00, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0});
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       en;
        logic [1:0] vld;
        logic [7:0] d0, d1;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[17];
    logic [5:0] pat;
    logic       act0, act1;
    logic [7:0] rd0, rd1;

    initial begin
        tbl[0]  = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0}};
        tbl[1]  = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0}};
        tbl[2]  = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0}};
        tbl[3]  = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0}};
        tbl[4]  = '{1'b0, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0}};
        tbl[5]  = '{1'b0, 2'b01, 8'd5, 8'd0, {2'b01, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0}};
        tbl[6]  = '{1'b0, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0}};
        tbl[7]  = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b1, 1'b1, 8'd5, 1'b0, 1'b0}};
        tbl[8]  = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0}};
        tbl[9]  = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0}};
        tbl[10] = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0}};
        tbl[11] = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0}};
        tbl[12] = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b1, 1'b1, 8'd5, 1'b0, 1'b0}};
        tbl[13] = '{1'b1, 2'b10, 8'd0, 8'd1, {2'b10, 1'b1, 1'b1, 1'b0, 8'd5, 1'b0, 1'b1}};
        tbl[14] = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0}};
        tbl[15] = '{1'b1, 2'b01, 8'd0, 8'd0, {2'b01, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1}};
        tbl[16] = '{1'b1, 2'b00, 8'd0, 8'd0, {2'b00, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0}};

        model_reset();
        @(posedge clk_in);
        #1 check("reset_state", w_dut, {2'b00, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0});
        #2 rst_n = 1'b1;

        // Divide-by-2, stop, div=5 load in IDLE, illegal divisors in RUN.
        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].en, tbl[i].vld, tbl[i].d0, tbl[i].d1);
            check($sformatf("vec%0d", i), w_dut, tbl[i].exp);
        end

        // Divisor change from 4 to 6 requested mid-period waits for the boundary.
        mid_reset();
        tick(1'b0, 2'b01, 8'd4, 8'd0);
        check("seqA_load4", w_dut, {2'b01, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0});
        tick(1'b1, 2'b00, 8'd0, 8'd0);
        tick(1'b1, 2'b00, 8'd0, 8'd0);
        check("seqA_cnt1", w_dut, {2'b00, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0});
        tick(1'b1, 2'b10, 8'd0, 8'd6);
        check("seqA_accept", w_dut, {2'b10, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0});
        tick(1'b1, 2'b00, 8'd0, 8'd0);
        check("seqA_still_pend", w_dut, {2'b00, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0});
        tick(1'b1, 2'b00, 8'd0, 8'd0);
        check("seqA_applied", w_dut, {2'b00, 1'b1, 1'b1, 1'b1, 8'd6, 1'b0, 1'b0});
        pat[5] = clk_out;
        for (int i = 4; i >= 0; i--) begin
            tick(1'b1, 2'b00, 8'd0, 8'd0);
            pat[i] = clk_out;
        end
        n_cmp++;
        if (pat !== 6'b111000) begin
            n_bad++;
            $display("FAIL seqA_div6_shape: got %b expected %b", pat, 6'b111000);
        end

        // Both requesters in IDLE: requester 0 first, then requester 1.
        mid_reset();
        tick(1'b0, 2'b11, 8'd3, 8'd7);
        check("seqB_first", w_dut, {2'b01, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0});
        tick(1'b0, 2'b11, 8'd3, 8'd7);
        check("seqB_second", w_dut, {2'b10, 1'b1, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0});
        tick(1'b0, 2'b00, 8'd0, 8'd0);
        check("seqB_quiet", w_dut, {2'b00, 1'b1, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0});

        // Reset while PEND at cnt=2 discards the pending divisor.
        mid_reset();
        tick(1'b0, 2'b01, 8'd5, 8'd0);
        tick(1'b1, 2'b00, 8'd0, 8'd0);
        tick(1'b1, 2'b10, 8'd0, 8'd3);
        tick(1'b1, 2'b00, 8'd0, 8'd0);
        check("seqC_pend_cnt2", w_dut, {2'b00, 1'b1, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0});
        mid_reset();
        tick(1'b1, 2'b00, 8'd0, 8'd0);
        check("seqC_resume", w_dut, {2'b00, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0});
        tick(1'b1, 2'b00, 8'd0, 8'd0);
        tick(1'b1, 2'b00, 8'd0, 8'd0);
        check("seqC_no_pending", w_dut, {2'b00, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0});

        // Randomized traffic: requesters hold a request until its ready pulse.
        mid_reset();
        act0 = 0; act1 = 0; rd0 = 0; rd1 = 0;
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                mid_reset();
                act0 = 0; act1 = 0;
            end
            if (!act0 && $urandom_range(0, 5) == 0) begin
                act0 = 1; rd0 = 8'($urandom_range(0, 9));
            end
            if (!act1 && $urandom_range(0, 5) == 0) begin
                act1 = 1; rd1 = 8'($urandom_range(0, 9));
            end
            tick($urandom_range(0, 7) != 0, {act1, act0}, rd0, rd1);
            if (m_ready[0]) act0 = 0;
            if (m_ready[1]) act1 = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
